vga_cell_framebuffer: RTL
=========================

Name: vga_cell_framebuffer

Overview:
- Sits downstream of the CPU's `VGA` instruction. It accepts single-cycle cell writes (3-bit colour, linear cell index = row*40 + col) and stores them in a 40x30-cell framebuffer.
- It continuously scans the framebuffer out as 640x480@60 Hz VGA, with each cell drawn as a 16x16-pixel block.
- It gives the CPU a frame-start pulse and a vertical-blank level so programs can sync redraws to the display.

Parameters:
- PIXEL_DIV, 2, Clock cycles per pixel (50 MHz Clock gives a 25 MHz pixel rate); legal values are 1..4.
- CELL_COLS, 40, number of cell columns.
- CELL_ROWS, 30, number of cell rows.
- CELL_SHIFT, 4, log2 of cell size in pixels (16).

Ports:
- Clock  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- iWriteEnable  in  1  write strobe, sampled on each rising Clock edge.
- iWriteAddress  in  16  linear cell index, 0..1199.
- iWriteColor  in  3  colour to store, {R,G,B}.
- oWriteError  out  1  one-cycle pulse when a write is rejected.
- oVGA_R  out  1  red output.
- oVGA_G  out  1  green output.
- oVGA_B  out  1  blue output.
- oVGA_HS  out  1  horizontal sync, active low.
- oVGA_VS  out  1  vertical sync, active low.
- oVBlank  out  1  high while the vertical counter is at or above 480.
- oFrameStart  out  1  one-Clock pulse when scan position wraps to (0,0).

Behaviour:
- Reset values:
  - Pixel divider, hCount and vCount = 0.
  - RGB = 0; HS = VS = 1; oVBlank = 0; oFrameStart = 0; oWriteError = 0.
  - Framebuffer contents are not cleared; software must paint every cell.
- Pixel tick: asserted for one Clock when the divider reaches PIXEL_DIV-1; the divider then wraps to 0. All scan logic advances only on a tick.
- Horizontal counter, 0..799:
  - Visible 0..639.
  - Front porch 640..655.
  - Sync 656..751 (HS low).
  - Back porch 752..799.
- Vertical counter, 0..524; increments when hCount wraps from 799 to 0:
  - Visible 0..479.
  - Front porch 480..489.
  - Sync 490..491 (VS low).
  - Back porch 492..524.
- oFrameStart: asserted on the tick where hCount wraps 799->0 and vCount wraps 524->0.
- Read address: (vCount>>CELL_SHIFT)*CELL_COLS + (hCount>>CELL_SHIFT), computed in 11 bits.
  - During blanking the address is don't-care; the output is forced to black.
- Scan pipeline (2 ticks, all stages registered on a tick):
  - Stage 1: RAM read, plus registered copies of the visible, hsync and vsync terms.
  - Stage 2: RGB = visible ? data : 0. HS and VS are taken from stage 1, so colour and sync stay aligned.
- Write path:
  - Runs every Clock, independent of the pixel tick.
  - If iWriteEnable is high and iWriteAddress < CELL_COLS*CELL_ROWS, the colour is stored at that address.
  - If iWriteEnable is high and the address is >= 1200, the write is dropped and oWriteError pulses one Clock later.
  - Writes are accepted back-to-back with no stall; there is no ready signal.
- Simultaneous write and read of the same cell: read-first. The scan shows the old colour for that pixel; the new colour appears from the next read.
- Reset asserted mid-frame: counters return to 0 on the next Clock edge. Pipeline registers clear to black with syncs inactive. The frame restarts at (0,0) with no oFrameStart pulse on the reset cycle itself.
- Widths:
  - hCount and vCount are 10 bits.
  - The row*40 product is computed as (row<<5)+(row<<3) so no multiplier is inferred.
  - iWriteAddress bits 15:11 must be zero for a write to be in range.

Decomposition:
- Shared package, vga_defs: H_VISIBLE, H_FRONT, H_SYNC, H_BACK, H_TOTAL, and the V_* equivalents.
- Also in vga_defs: the colour constants (COLOR_BLACK..COLOR_WHITE as 3-bit RGB) and CELL_COUNT = 1200.
- Sub-module vga_timing_gen: owns the divider, counters, sync/visible terms and oFrameStart.
- The top level holds the 1200x3 dual-port RAM (one write port, one read port), the address arithmetic and the output pipeline.

Test Plan:
- Reset held 3 cycles, then released -> HS = VS = 1 and RGB = 0. First HS falling edge at pixel 656 of line 0, i.e. Clock 1312 after release with PIXEL_DIV = 2. HS low for exactly 192 Clocks.
- Free-run one frame -> VS low during lines 490..491 only. oFrameStart pulses every 800*525*2 = 840000 Clocks. oVBlank is high for lines 480..524.
- Write colour 3'b110 (yellow) to address 33 + 3*40 = 153 -> pixels h 528..543, v 48..63 show R = G = 1, B = 0, appearing 2 ticks after counter entry. Neighbouring cells are unchanged.
- Write address 1200 with colour 3'b111 -> oWriteError pulses for 1 cycle and cell 0 is unchanged. A following valid write to address 1199 lands at h 624..639, v 464..479.
- Write 3'b010 to a cell on the exact tick it is being read (previously 3'b001) -> that pixel shows 3'b001 and the next pixel shows 3'b010.
- Assert Reset at line 200, pixel 300 -> next Clock outputs are black with syncs high. Scan resumes at (0,0) and the next oFrameStart arrives after 840000 Clocks.

Source files
------------

// File: rtl/vga_defs.sv
// vga_defs: shared constants for the cell framebuffer.
//   640x480@60 horizontal/vertical timing (visible, front porch, sync, back porch, total),
//   3-bit {R,G,B} colour encodings and the framebuffer cell count.
package vga_defs;

    localparam int unsigned H_VISIBLE = 640;
    localparam int unsigned H_FRONT   = 16;
    localparam int unsigned H_SYNC    = 96;
    localparam int unsigned H_BACK    = 48;
    localparam int unsigned H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

    localparam int unsigned V_VISIBLE = 480;
    localparam int unsigned V_FRONT   = 10;
    localparam int unsigned V_SYNC    = 2;
    localparam int unsigned V_BACK    = 33;
    localparam int unsigned V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam int unsigned CELL_COUNT = 1200;

    typedef enum logic [2:0] {
        COLOR_BLACK   = 3'b000,
        COLOR_BLUE    = 3'b001,
        COLOR_GREEN   = 3'b010,
        COLOR_CYAN    = 3'b011,
        COLOR_RED     = 3'b100,
        COLOR_MAGENTA = 3'b101,
        COLOR_YELLOW  = 3'b110,
        COLOR_WHITE   = 3'b111
    } color_t;

endpackage

// File: rtl/vga_cell_framebuffer_if.sv
// vga_cell_framebuffer_if: CPU-side cell write bus.
//   iWriteEnable   single-cycle write strobe
//   iWriteAddress  linear cell index (row*cols + col)
//   iWriteColor    {R,G,B} colour to store
//   oWriteError    one-cycle pulse, one Clock after a rejected write
// master = CPU side, slave = framebuffer side.
interface vga_cell_framebuffer_if;

    logic        iWriteEnable;
    logic [15:0] iWriteAddress;
    logic [2:0]  iWriteColor;
    logic        oWriteError;

    modport master (
        output iWriteEnable,
        output iWriteAddress,
        output iWriteColor,
        input  oWriteError
    );

    modport slave (
        input  iWriteEnable,
        input  iWriteAddress,
        input  iWriteColor,
        output oWriteError
    );

endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: pixel-rate divider and raster counters.
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   tick          one-clk pixel enable (every PIXEL_DIV clocks)
//   h_count       horizontal position 0..H_TOTAL-1
//   v_count       vertical position 0..V_TOTAL-1
//   visible       current position is inside the visible area
//   hsync, vsync  sync terms for the current position, active low
//   vblank        vertical counter at or beyond the visible lines
//   frame_start   one-clk pulse after the scan wraps to (0,0)
module vga_timing_gen
    import vga_defs::*;
#(
    parameter int unsigned PIXEL_DIV = 2,
    parameter int unsigned H_VIS     = H_VISIBLE,
    parameter int unsigned H_FP      = H_FRONT,
    parameter int unsigned H_SW      = H_SYNC,
    parameter int unsigned H_BP      = H_BACK,
    parameter int unsigned V_VIS     = V_VISIBLE,
    parameter int unsigned V_FP      = V_FRONT,
    parameter int unsigned V_SW      = V_SYNC,
    parameter int unsigned V_BP      = V_BACK
) (
    input  logic       clk,
    input  logic       rst,
    output logic       tick,
    output logic [9:0] h_count,
    output logic [9:0] v_count,
    output logic       visible,
    output logic       hsync,
    output logic       vsync,
    output logic       vblank,
    output logic       frame_start
);

    localparam logic [1:0] DIV_LAST     = 2'(PIXEL_DIV - 1);
    localparam logic [9:0] H_VIS_END    = 10'(H_VIS);
    localparam logic [9:0] H_SYNC_BEG   = 10'(H_VIS + H_FP);
    localparam logic [9:0] H_SYNC_END   = 10'(H_VIS + H_FP + H_SW);
    localparam logic [9:0] H_LAST       = 10'(H_VIS + H_FP + H_SW + H_BP - 1);
    localparam logic [9:0] V_VIS_END    = 10'(V_VIS);
    localparam logic [9:0] V_SYNC_BEG   = 10'(V_VIS + V_FP);
    localparam logic [9:0] V_SYNC_END   = 10'(V_VIS + V_FP + V_SW);
    localparam logic [9:0] V_LAST       = 10'(V_VIS + V_FP + V_SW + V_BP - 1);

    logic [1:0] div;
    logic       h_last;
    logic       v_last;

    assign tick   = (div == DIV_LAST);
    assign h_last = (h_count == H_LAST);
    assign v_last = (v_count == V_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            div <= '0;
        end else if (tick) begin
            div <= '0;
        end else begin
            div <= div + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_count     <= '0;
            v_count     <= '0;
            frame_start <= 1'b0;
        end else begin
            // Registered so the pulse coincides with the counters sitting at (0,0).
            frame_start <= tick && h_last && v_last;
            if (tick) begin
                if (h_last) begin
                    h_count <= '0;
                    if (v_last) begin
                        v_count <= '0;
                    end else begin
                        v_count <= v_count + 10'd1;
                    end
                end else begin
                    h_count <= h_count + 10'd1;
                end
            end
        end
    end

    always_comb begin
        visible = (h_count < H_VIS_END) && (v_count < V_VIS_END);
        hsync   = !((h_count >= H_SYNC_BEG) && (h_count < H_SYNC_END));
        vsync   = !((v_count >= V_SYNC_BEG) && (v_count < V_SYNC_END));
        vblank  = (v_count >= V_VIS_END);
    end

endmodule

// File: rtl/vga_cell_framebuffer.sv
// vga_cell_framebuffer: CELL_COLS x CELL_ROWS cell framebuffer (3-bit colour) scanned out
// as VGA, each cell drawn as a (1<<CELL_SHIFT)-pixel square block.
// Ports:
//   Clock, Reset   system clock, synchronous active-high reset
//   wr             cell write bus (slave): write strobe/address/colour in, error pulse out
//   oVGA_R/G/B     pixel colour, black outside the visible area
//   oVGA_HS/VS     horizontal/vertical sync, active low, aligned with the colour
//   oVBlank        vertical counter at or beyond the visible lines
//   oFrameStart    one-Clock pulse when the scan wraps to (0,0)
module vga_cell_framebuffer
    import vga_defs::*;
#(
    parameter int unsigned PIXEL_DIV  = 2,
    parameter int unsigned CELL_COLS  = 40,
    parameter int unsigned CELL_ROWS  = 30,
    parameter int unsigned CELL_SHIFT = 4,
    parameter int unsigned H_VIS      = H_VISIBLE,
    parameter int unsigned H_FP       = H_FRONT,
    parameter int unsigned H_SW       = H_SYNC,
    parameter int unsigned H_BP       = H_BACK,
    parameter int unsigned V_VIS      = V_VISIBLE,
    parameter int unsigned V_FP       = V_FRONT,
    parameter int unsigned V_SW       = V_SYNC,
    parameter int unsigned V_BP       = V_BACK
) (
    input  logic                   Clock,
    input  logic                   Reset,
    vga_cell_framebuffer_if.slave  wr,
    output logic                   oVGA_R,
    output logic                   oVGA_G,
    output logic                   oVGA_B,
    output logic                   oVGA_HS,
    output logic                   oVGA_VS,
    output logic                   oVBlank,
    output logic                   oFrameStart
);

    localparam int unsigned CELLS = CELL_COLS * CELL_ROWS;

    logic       tick;
    logic [9:0] h_count;
    logic [9:0] v_count;
    logic       visible;
    logic       hsync;
    logic       vsync;

    vga_timing_gen #(
        .PIXEL_DIV (PIXEL_DIV),
        .H_VIS     (H_VIS),
        .H_FP      (H_FP),
        .H_SW      (H_SW),
        .H_BP      (H_BP),
        .V_VIS     (V_VIS),
        .V_FP      (V_FP),
        .V_SW      (V_SW),
        .V_BP      (V_BP)
    ) u_timing (
        .clk         (Clock),
        .rst         (Reset),
        .tick        (tick),
        .h_count     (h_count),
        .v_count     (v_count),
        .visible     (visible),
        .hsync       (hsync),
        .vsync       (vsync),
        .vblank      (oVBlank),
        .frame_start (oFrameStart)
    );

    // Cell storage: one write port (CPU), one read port (scan-out).
    logic [2:0] cells [0:CELLS-1];

    // Full 16-bit compare, so any of bits 15:11 set also rejects the write.
    logic wr_in_range;
    logic wr_error;

    assign wr_in_range    = (wr.iWriteAddress < 16'(CELLS));
    assign wr.oWriteError = wr_error;

    always_ff @(posedge Clock) begin
        if (wr.iWriteEnable && wr_in_range) begin
            cells[wr.iWriteAddress[10:0]] <= wr.iWriteColor;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            wr_error <= 1'b0;
        end else begin
            wr_error <= wr.iWriteEnable && !wr_in_range;
        end
    end

    // Read address; blanking positions may point past the array, masked by 'visible'.
    logic [10:0] row;
    logic [10:0] col;
    logic [10:0] rd_addr;

    assign row = 11'(v_count >> CELL_SHIFT);
    assign col = 11'(h_count >> CELL_SHIFT);

    generate
        if (CELL_COLS == 40) begin : g_mul40
            assign rd_addr = (row << 5) + (row << 3) + col;
        end else begin : g_mul
            assign rd_addr = 11'(row * CELL_COLS) + col;
        end
    endgenerate

    // Stage 1: RAM read plus delayed visible/sync terms. The read register carries
    // no reset so it maps onto the RAM's output register; 'vis_s1' masks it after reset.
    logic [2:0] rd_data;
    logic       vis_s1;
    logic       hs_s1;
    logic       vs_s1;
    logic [2:0] rgb;
    logic       hs_out;
    logic       vs_out;

    always_ff @(posedge Clock) begin
        if (tick) begin
            rd_data <= cells[rd_addr];
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            vis_s1 <= 1'b0;
            hs_s1  <= 1'b1;
            vs_s1  <= 1'b1;
            rgb    <= COLOR_BLACK;
            hs_out <= 1'b1;
            vs_out <= 1'b1;
        end else if (tick) begin
            vis_s1 <= visible;
            hs_s1  <= hsync;
            vs_s1  <= vsync;
            rgb    <= vis_s1 ? rd_data : COLOR_BLACK;
            hs_out <= hs_s1;
            vs_out <= vs_s1;
        end
    end

    assign oVGA_R  = rgb[2];
    assign oVGA_G  = rgb[1];
    assign oVGA_B  = rgb[0];
    assign oVGA_HS = hs_out;
    assign oVGA_VS = vs_out;

endmodule
